// File: rtl/micro_q_pkg.sv
// Shared definitions for the micro-op queue and its producers.
//   OP_W / PAY_W    : opcode and packed payload widths
//   NOP_OP          : opcode value that marks an empty fetch slot
//   micro_payload_t : field layout of the packed payload
//   wrap_add        : modulo-DEPTH pointer increment without power-of-two masking
package micro_q_pkg;

    localparam int OP_W  = 8;
    localparam int PAY_W = 128;
    localparam logic [OP_W-1:0] NOP_OP = '0;

    // 6+6+6+32+32+2+44 = 128 bits, most significant field first.
    typedef struct packed {
        logic [5:0]  reg_d;
        logic [5:0]  reg_s;
        logic [5:0]  reg_t;
        logic [31:0] imm;
        logic [31:0] disp;
        logic [1:0]  bit_mode;
        logic [43:0] pc;
    } micro_payload_t;

    // Valid while ptr < depth and inc <= depth, so one conditional subtract
    // is enough and any depth (not just powers of two) works.
    function automatic int unsigned wrap_add(input int unsigned ptr,
                                             input int unsigned inc,
                                             input int unsigned depth);
        int unsigned sum;
        sum = ptr + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

endpackage

// File: rtl/micro_compact.sv
// Slot compaction helper: prefix popcount over a fetch bundle.
//   opcode : IN_N opcodes, slot 0 first
//   live   : per-slot flag, opcode != NOP_OP
//   rank   : number of live slots strictly below this one (write offset)
//   n_live : total live slots in the bundle
// Purely combinational; also used by the fetch stage.
module micro_compact #(
    parameter int IN_N = 4,
    parameter int OP_W = micro_q_pkg::OP_W,
    parameter logic [OP_W-1:0] NOP_OP = micro_q_pkg::NOP_OP
) (
    input  logic [IN_N-1:0][OP_W-1:0]            opcode,
    output logic [IN_N-1:0]                      live,
    output logic [IN_N-1:0][$clog2(IN_N+1)-1:0]  rank,
    output logic [$clog2(IN_N+1)-1:0]            n_live
);

    localparam int CNT_W = $clog2(IN_N + 1);

    always_comb begin
        logic [CNT_W-1:0] acc;
        acc    = '0;
        live   = '0;
        rank   = '0;
        n_live = '0;
        for (int i = 0; i < IN_N; i++) begin
            live[i] = (opcode[i] != NOP_OP);
            rank[i] = acc;
            acc     = acc + CNT_W'(live[i]);
        end
        n_live = acc;
    end

endmodule

// File: rtl/micro_op_queue.sv
// Micro-op queue between fetch/expand and decode/issue.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : discard all contents (mispredict / exception)
//   in_valid      : fetch bundle present
//   in_ready      : room for a full bundle (from registered count only)
//   in_opcode     : IN_N opcodes, NOP_OP marks an empty slot
//   in_payload    : IN_N packed payloads
//   out_valid     : out_valid[k] = entry k (0 = oldest) holds an op
//   out_opcode    : opcode of entry k, NOP_OP when invalid
//   out_payload   : payload of entry k, don't-care when invalid
//   out_pop       : number of head entries consumed this cycle
//   count/empty/full : occupancy status
// NOP slots are squeezed out on write; live ops keep their slot order.
module micro_op_queue #(
    parameter int DEPTH = 16,
    parameter int IN_N  = 4,
    parameter int OUT_N = 2,
    parameter int OP_W  = micro_q_pkg::OP_W,
    parameter int PAY_W = micro_q_pkg::PAY_W,
    parameter logic [OP_W-1:0] NOP_OP = micro_q_pkg::NOP_OP
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [IN_N-1:0][OP_W-1:0]         in_opcode,
    input  logic [IN_N-1:0][PAY_W-1:0]        in_payload,
    output logic [OUT_N-1:0]                  out_valid,
    output logic [OUT_N-1:0][OP_W-1:0]        out_opcode,
    output logic [OUT_N-1:0][PAY_W-1:0]       out_payload,
    input  logic [$clog2(OUT_N+1)-1:0]        out_pop,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              empty,
    output logic                              full
);

    import micro_q_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int POP_W = $clog2(OUT_N + 1);
    localparam int NP_W  = $clog2(IN_N + 1);

    logic [OP_W-1:0]              mem_op  [DEPTH];
    logic [PAY_W-1:0]             mem_pay [DEPTH];
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;

    logic [IN_N-1:0]              live;
    logic [IN_N-1:0][NP_W-1:0]    rank;
    logic [NP_W-1:0]              n_push;
    logic [NP_W-1:0]              n_acc;
    logic                         push_fire;
    logic                         wr_en;
    logic [POP_W-1:0]             valid_cnt;
    logic [POP_W-1:0]             pop_eff;
    logic [PTR_W-1:0]             wr_idx [IN_N];
    logic [PTR_W-1:0]             rd_idx [OUT_N];

    micro_compact #(
        .IN_N   (IN_N),
        .OP_W   (OP_W),
        .NOP_OP (NOP_OP)
    ) u_compact (
        .opcode (in_opcode),
        .live   (live),
        .rank   (rank),
        .n_live (n_push)
    );

    // Same-cycle pops are deliberately not credited so in_ready has no
    // combinational path from the consumer.
    assign in_ready  = (DEPTH - int'(count)) >= IN_N;
    assign push_fire = in_valid & in_ready;
    assign wr_en     = push_fire & ~flush & ~rst;
    assign n_acc     = push_fire ? n_push : '0;
    assign empty     = (count == '0);
    assign full      = (int'(count) == DEPTH);

    // An over-pop is clamped to what is actually presented.
    always_comb begin
        valid_cnt = (int'(count) >= OUT_N) ? POP_W'(OUT_N) : POP_W'(count);
        pop_eff   = (out_pop > valid_cnt) ? valid_cnt : out_pop;
    end

    always_comb begin
        for (int i = 0; i < IN_N; i++) begin
            wr_idx[i] = PTR_W'(wrap_add(32'(tail), 32'(rank[i]), DEPTH));
        end
    end

    // Read mux straight from storage; entries pushed this cycle show up next cycle.
    always_comb begin
        out_valid   = '0;
        out_opcode  = '0;
        out_payload = '0;
        for (int k = 0; k < OUT_N; k++) begin
            rd_idx[k]      = PTR_W'(wrap_add(32'(head), k, DEPTH));
            out_valid[k]   = int'(count) > k;
            out_opcode[k]  = out_valid[k] ? mem_op[rd_idx[k]] : NOP_OP;
            out_payload[k] = mem_pay[rd_idx[k]];
        end
    end

    // Control state: rst > flush > {push, pop}. Pop uses the pre-update head,
    // push the pre-update tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= PTR_W'(wrap_add(32'(head), 32'(pop_eff), DEPTH));
            tail  <= PTR_W'(wrap_add(32'(tail), 32'(n_acc), DEPTH));
            count <= count + CNT_W'(n_acc) - CNT_W'(pop_eff);
        end
    end

    // Storage is never cleared; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < IN_N; i++) begin
                if (live[i]) begin
                    mem_op[wr_idx[i]]  <= in_opcode[i];
                    mem_pay[wr_idx[i]] <= in_payload[i];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (int'(count) <= DEPTH)
                else $error("occupancy %0d above depth %0d", count, DEPTH);
            assert (!(wr_en && !in_ready))
                else $error("push accepted without room");
            assert (out_pop <= valid_cnt)
                else $warning("protocol: out_pop %0d exceeds %0d valid entries, pop clamped",
                              out_pop, valid_cnt);
        end
    end

endmodule
